jedro_1_dmem_arbiter: RTL and testbench

- Shares the single-port byte-write data RAM between two requesters.
  - Port 0: the core load/store path.
  - Port 1: an auxiliary master such as the bench preloader or a future DMA.
- Grants at most one access per cycle and drives the RAM.
- Routes each read response back to its originator after the fixed RAM latency.
- Sits between jedro_1_top's data interface and bytewrite_ram_wrap.

---
 rtl/jedro_1_dmem_pkg.sv | 24 ++
 rtl/jedro_1_rr_arbiter.sv | 33 +++
 rtl/jedro_1_dmem_arbiter.sv | 92 +++++++++
 tb/tb_jedro_1_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_dmem_pkg.sv
// rtl/jedro_1_dmem_pkg.sv - shared types and constants for the data-memory arbiter
package jedro_1_dmem_pkg;

  localparam int NUM_MASTERS     = 2;
  localparam int DMEM_ADDR_WIDTH = 32;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int BE_WIDTH        = DMEM_DATA_WIDTH / 8;

  typedef logic master_id_t;

  typedef struct packed {
    logic                       we;
    logic [BE_WIDTH-1:0]        be;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [DMEM_DATA_WIDTH-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
    logic       err;
  } rsp_tag_t;

endpackage

// File: rtl/jedro_1_rr_arbiter.sv
// rtl/jedro_1_rr_arbiter.sv - two-input round-robin grant with last-granted pointer
module jedro_1_rr_arbiter
  import jedro_1_dmem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt
);

  master_id_t last_q;

  // Reset to "last = 1" so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/jedro_1_dmem_arbiter.sv
// rtl/jedro_1_dmem_arbiter.sv - shares the byte-write data RAM between core and aux masters
module jedro_1_dmem_arbiter
  import jedro_1_dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_LAT    = 1,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NUM_MASTERS-1:0]                   m_req_i,
  input  logic [NUM_MASTERS-1:0]                   m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]                   m_gnt_o,
  output logic [NUM_MASTERS-1:0]                   m_rvalid_o,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_rdata_o,
  output logic [NUM_MASTERS-1:0]                   m_err_o,
  output logic                                     ram_en_o,
  output logic [DATA_WIDTH/8-1:0]                  ram_we_o,
  output logic [ADDR_WIDTH-3:0]                    ram_addr_o,
  output logic [DATA_WIDTH-1:0]                    ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]                    ram_rdata_i
);

  master_id_t sel;
  logic       granted;
  logic       in_range;
  rsp_tag_t   new_tag;
  rsp_tag_t   out_tag;
  rsp_tag_t   pipe_q [RAM_LAT];

  jedro_1_rr_arbiter u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .req (m_req_i),
    .gnt (m_gnt_o)
  );

  assign granted  = |m_gnt_o;
  assign sel      = m_gnt_o[1];
  assign in_range = m_addr_i[sel] < ADDR_WIDTH'(MEM_BYTES);

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (granted && in_range) begin
      ram_en_o    = 1'b1;
      ram_we_o    = m_we_i[sel] ? m_be_i[sel] : '0;
      ram_addr_o  = m_addr_i[sel][ADDR_WIDTH-1:2];
      ram_wdata_o = m_wdata_i[sel];
    end
  end

  // Out-of-range reads still travel the pipe so they answer with err; writes never do.
  always_comb begin
    new_tag.valid = granted && !m_we_i[sel];
    new_tag.id    = sel;
    new_tag.err   = !in_range;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= new_tag;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_tag = pipe_q[RAM_LAT-1];

  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    if (out_tag.valid && !rst_i) begin
      m_rvalid_o[out_tag.id] = 1'b1;
      m_err_o[out_tag.id]    = out_tag.err;
      m_rdata_o[out_tag.id]  = out_tag.err ? '0 : ram_rdata_i;
    end
  end

endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// tb/tb_jedro_1_dmem_arbiter.sv - randomized bench for the dmem arbiter at RAM_LAT 1 and 2
module tb_jedro_1_dmem_arbiter;

  localparam int MEM_BYTES = 4096;
  localparam int WORDS     = MEM_BYTES / 4;

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             preload;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;

  logic [1:0]       gnt_o  [2];
  logic [1:0]       rv_o   [2];
  logic [1:0][31:0] rd_o   [2];
  logic [1:0]       err_o  [2];
  logic             en_o   [2];
  logic [3:0]       rwe_o  [2];
  logic [29:0]      ra_o   [2];
  logic [31:0]      wd_o   [2];
  logic [31:0]      rr_a, rr_b1, rr_b;

  logic [31:0] mem_a     [WORDS];
  logic [31:0] mem_b     [WORDS];
  logic [31:0] model_mem [WORDS];
  logic        model_last;
  logic [1:0]  last_eg;
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc, n_vec, n_bad;

  jedro_1_dmem_arbiter #(.RAM_LAT(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .m_req_i(req), .m_we_i(we), .m_be_i(be),
    .m_addr_i(addr), .m_wdata_i(wdata), .m_gnt_o(gnt_o[0]), .m_rvalid_o(rv_o[0]),
    .m_rdata_o(rd_o[0]), .m_err_o(err_o[0]), .ram_en_o(en_o[0]), .ram_we_o(rwe_o[0]),
    .ram_addr_o(ra_o[0]), .ram_wdata_o(wd_o[0]), .ram_rdata_i(rr_a)
  );

  jedro_1_dmem_arbiter #(.RAM_LAT(2)) u_dut_l2 (
    .clk_i(clk), .rst_i(rst), .m_req_i(req), .m_we_i(we), .m_be_i(be),
    .m_addr_i(addr), .m_wdata_i(wdata), .m_gnt_o(gnt_o[1]), .m_rvalid_o(rv_o[1]),
    .m_rdata_o(rd_o[1]), .m_err_o(err_o[1]), .ram_en_o(en_o[1]), .ram_we_o(rwe_o[1]),
    .ram_addr_o(ra_o[1]), .ram_wdata_o(wd_o[1]), .ram_rdata_i(rr_b)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 0) return 32'h11;
    if (i == 1) return 32'h22;
    return {16'(i), 16'hA5A5 ^ 16'(i)};
  endfunction

  // Read-first byte-write RAMs: one cycle deep for L1, two for L2.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) mem_a[i] <= init_word(i);
    end else if (en_o[0]) begin
      rr_a <= mem_a[ra_o[0][9:0]];
      for (int i = 0; i < 4; i++)
        if (rwe_o[0][i]) mem_a[ra_o[0][9:0]][8*i +: 8] <= wd_o[0][8*i +: 8];
    end
  end

  always @(posedge clk) begin
    rr_b <= rr_b1;
    if (preload) begin
      for (int i = 0; i < WORDS; i++) mem_b[i] <= init_word(i);
    end else if (en_o[1]) begin
      rr_b1 <= mem_b[ra_o[1][9:0]];
      for (int i = 0; i < 4; i++)
        if (rwe_o[1][i]) mem_b[ra_o[1][9:0]][8*i +: 8] <= wd_o[1][8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_rsp(input int k, input logic hit, input exp_t e);
    logic [1:0]       ev;
    logic [1:0]       ee;
    logic [1:0][31:0] ed;
    ev = '0; ee = '0; ed = '0;
    if (hit) begin
      ev[e.id] = 1'b1;
      ee[e.id] = e.err;
      ed[e.id] = e.data;
    end
    chk($sformatf("rvalid L%0d", k + 1), 64'(rv_o[k]), 64'(ev));
    chk($sformatf("rdata L%0d", k + 1), 64'(rd_o[k]), 64'(ed));
    if (rst) chk($sformatf("err_rst L%0d", k + 1), 64'(err_o[k]), 64'd0);
    else     chk($sformatf("err L%0d", k + 1), 64'(err_o[k] & ev), 64'(ee));
  endtask

  task automatic step();
    logic [1:0]  eg;
    logic        id, inr, hit0, hit1;
    logic [31:0] a, d;
    exp_t        e0, e1;
    @(negedge clk);
    hit0 = 1'b0; hit1 = 1'b0;
    e0 = '{0, 1'b0, 32'd0, 1'b0};
    e1 = e0;
    if (q0.size() > 0 && q0[0].due == cyc) begin e0 = q0.pop_front(); hit0 = 1'b1; end
    if (q1.size() > 0 && q1[0].due == cyc) begin e1 = q1.pop_front(); hit1 = 1'b1; end
    chk_rsp(0, hit0 && !rst, e0);
    chk_rsp(1, hit1 && !rst, e1);

    if (rst) begin
      eg = 2'b00;
      q0.delete();
      q1.delete();
    end else if (req == 2'b11) begin
      eg = model_last ? 2'b01 : 2'b10;
    end else begin
      eg = req;
    end
    for (int k = 0; k < 2; k++) chk($sformatf("gnt L%0d", k + 1), 64'(gnt_o[k]), 64'(eg));

    if (eg != 2'b00) begin
      id  = eg[1];
      a   = addr[id];
      inr = a < MEM_BYTES;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ram_en L%0d", k + 1), 64'(en_o[k]), 64'(inr));
        if (inr) begin
          chk($sformatf("ram_we L%0d", k + 1), 64'(rwe_o[k]), 64'(we[id] ? be[id] : 4'h0));
          chk($sformatf("ram_addr L%0d", k + 1), 64'(ra_o[k]), 64'(a[31:2]));
          if (we[id]) chk($sformatf("ram_wdata L%0d", k + 1), 64'(wd_o[k]), 64'(wdata[id]));
        end
      end
      if (!we[id]) begin
        d = inr ? model_mem[a[11:2]] : 32'd0;
        q0.push_back('{cyc + 1, id, d, !inr});
        q1.push_back('{cyc + 2, id, d, !inr});
      end else if (inr) begin
        for (int i = 0; i < 4; i++)
          if (be[id][i]) model_mem[a[11:2]][8*i +: 8] = wdata[id][8*i +: 8];
      end
      model_last = id;
    end else begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ram_en_idle L%0d", k + 1), 64'(en_o[k]), 64'd0);
        if (rst) chk($sformatf("ram_bus_rst L%0d", k + 1), {rwe_o[k], ra_o[k], wd_o[k]}, 64'd0);
      end
    end
    if (rst) model_last = 1'b1;
    last_eg = eg;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_m(input int m, input logic w, input logic [3:0] b,
                       input logic [31:0] ad, input logic [31:0] wd);
    req[m]   = 1'b1;
    we[m]    = w;
    be[m]    = b;
    addr[m]  = ad;
    wdata[m] = wd;
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_bad = 0;
    rst = 1'b1; preload = 1'b1;
    req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    model_last = 1'b1; last_eg = '0;
    for (int i = 0; i < WORDS; i++) model_mem[i] = init_word(i);
    @(posedge clk);
    #1;
    preload = 1'b0;
    step();
    step();
    rst = 1'b0;

    // single write then read-back from the core
    req = '0; set_m(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF); step();
    req = '0; set_m(0, 1'b0, 4'hF, 32'h10, 32'h0);        step();
    req = '0; step(); step();

    // contention after a fresh reset: core must win first
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_m(0, 1'b0, 4'hF, 32'h0, 32'h0);
      set_m(1, 1'b0, 4'hF, 32'h4, 32'h0);
      step();
    end
    req = '0; step(); step();

    // partial byte write from aux
    req = '0; set_m(1, 1'b1, 4'hF, 32'h20, 32'hFFFFFFFF); step();
    req = '0; set_m(1, 1'b1, 4'h2, 32'h20, 32'h0000AB00); step();
    req = '0; set_m(1, 1'b0, 4'hF, 32'h20, 32'h0);        step();
    req = '0; step(); step();

    // out-of-range read and write
    req = '0; set_m(0, 1'b0, 4'hF, MEM_BYTES, 32'h0);        step();
    req = '0; set_m(0, 1'b1, 4'hF, MEM_BYTES, 32'h12345678); step();
    req = '0; step(); step();

    // reset while an aux read is in flight
    req = '0; set_m(1, 1'b0, 4'hF, 32'h4, 32'h0); step();
    req = '0; rst = 1'b1; step(); rst = 1'b0;
    set_m(0, 1'b0, 4'hF, 32'h8, 32'h0);
    set_m(1, 1'b0, 4'hF, 32'hC, 32'h0);
    step();
    req[0] = 1'b0; step();
    req = '0; step(); step();

    // back-to-back core reads
    for (int i = 0; i < 3; i++) begin
      req = '0; set_m(0, 1'b0, 4'hF, 32'(4 * i), 32'h0); step();
    end
    req = '0; step(); step(); step();

    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] || last_eg[m]) begin
          if ($urandom_range(0, 9) < 6) begin
            set_m(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 32'(MEM_BYTES + $urandom_range(0, 255))
                                              : 32'($urandom_range(0, 127)),
                  $urandom);
          end else begin
            req[m] = 1'b0;
          end
        end
      end
      rst = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0; req = '0;
    step(); step(); step();
    chk("drain", 64'(q0.size() + q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
